uart_tx_frame: RTL

- Serial UART transmitter: the transmit-side counterpart of the receive path's framing and parity checking.
- Accepts a parallel byte with a valid strobe.
- Shifts out one frame: start bit, data LSB-first, optional parity bit, stop bit. One bit per CLK cycle; CLK is the already-divided TX bit clock.
- Parity convention matches the receive checker: PAR_TYP=0 even, PAR_TYP=1 odd.

---
 rtl/uart_tx_frame.sv | 76 +++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART frame transmitter; in CLK, RST, P_DATA, DATA_VALID, PAR_EN, PAR_TYP; out TX_OUT (serial line), BUSY (frame in progress)
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                  r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_par_en, r_par, r_tx, r_busy, w_tx, w_busy, w_last;
  assign w_last = r_cnt == CW'(DATA_WIDTH - 1);
  assign TX_OUT = r_tx;
  assign BUSY   = r_busy;
  always_comb begin
    w_next = r_state;
    w_tx   = 1'b1;
    w_busy = 1'b1;
    case (r_state)
      IDLE: begin
        w_next = DATA_VALID ? START : IDLE;
        w_tx   = ~DATA_VALID;
        w_busy = DATA_VALID;
      end
      START: begin
        w_next = DATA;
        w_tx   = r_shift[0];
      end
      DATA: begin
        w_next = w_last ? (r_par_en ? PARITY : STOP) : DATA;
        w_tx   = w_last ? (~r_par_en | r_par) : r_shift[1];
      end
      PARITY: w_next = STOP;
      STOP: begin
        w_next = IDLE;
        w_busy = 1'b0;
      end
      default: begin
        w_next = IDLE;
        w_busy = 1'b0;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      if (r_state == IDLE && DATA_VALID) begin
        r_shift  <= P_DATA;
        r_par_en <= PAR_EN;
        r_par    <= PAR_TYP ? ~^P_DATA : ^P_DATA;
        r_cnt    <= '0;
      end else if (r_state == DATA) begin
        r_shift <= r_shift >> 1;
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end
endmodule
